// File: rtl/fm_modulator_mc.sv
// -----------------------------------------------------------------------------
// fm_modulator_mc
//   Multi-channel FM modulator. Each accepted sample advances the phase
//   accumulator of its channel by (carrier + sample >>> DEV_SHIFT); the new
//   phase is folded onto a quarter-wave sine ROM and the signed result is
//   emitted with its channel tag. Four-stage pipeline with valid/ready flow
//   control on both sides.
//
// Ports:
//   clock, reset          system clock, synchronous active-high reset
//   io_in_valid/ready     input handshake (ready depends only on output side)
//   io_in_value           signed modulating sample
//   io_in_channel         target accumulator; indices >= CHANNELS are dropped
//   io_cfg_carrier        carrier frequency word, sampled on each accept
//   io_cfg_phase_clear    pulse: zero all accumulators (honoured while stalled)
//   io_out_valid/ready    output handshake
//   io_out_value          signed sine sample
//   io_out_channel        channel tag of io_out_value
// -----------------------------------------------------------------------------
module fm_modulator_mc #(
   parameter int DATA_W     = 32,
   parameter int PHASE_W    = 32,
   parameter int LUT_ADDR_W = 10,
   parameter int OUT_W      = 16,
   parameter int CHANNELS   = 4,
   parameter int DEV_SHIFT  = 0,
   localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_in_valid,
   output logic                      io_in_ready,
   input  logic signed [DATA_W-1:0]  io_in_value,
   input  logic [CH_W-1:0]           io_in_channel,
   input  logic [PHASE_W-1:0]        io_cfg_carrier,
   input  logic                      io_cfg_phase_clear,
   output logic                      io_out_valid,
   input  logic                      io_out_ready,
   output logic signed [OUT_W-1:0]   io_out_value,
   output logic [CH_W-1:0]           io_out_channel
);

   localparam int  EXT_W = (DATA_W > PHASE_W) ? DATA_W : PHASE_W;
   localparam int  LUT_N = 1 << LUT_ADDR_W;
   localparam int  AMP   = (1 << (OUT_W - 1)) - 1;
   localparam int  TOP_W = LUT_ADDR_W + 2;
   localparam real PI    = 3.14159265358979323846;

   // Quarter-wave entry k = round(AMP * sin(pi*(k+0.5)/(2N))), evaluated at
   // elaboration with a Taylor series (x <= pi/2, error far below 1 LSB).
   function automatic logic [OUT_W-2:0] lut_entry(input int unsigned k);
      real x;
      real term;
      real sum;
      int  r;
      x    = PI * (real'(k) + 0.5) / (2.0 * real'(LUT_N));
      term = x;
      sum  = x;
      for (int unsigned i = 1; i < 12; i++) begin
         term = -term * x * x / real'((2 * i) * (2 * i + 1));
         sum  = sum + term;
      end
      r = $rtoi(sum * real'(AMP) + 0.5);
      return (OUT_W-1)'(r);
   endfunction

   logic [OUT_W-2:0] rom [LUT_N];

   for (genvar k = 0; k < LUT_N; k++) begin : g_rom
      assign rom[k] = lut_entry(k);
   end

   // ---------------------------------------------------------------- front end
   logic                     en;
   logic                     accept;
   logic                     in_range;
   logic [31:0]              ch_idx;
   logic [CH_W-1:0]          ch_sel;
   logic signed [EXT_W-1:0]  sample_ext;
   logic signed [EXT_W-1:0]  sample_shift;
   logic [PHASE_W-1:0]       inc;
   logic [PHASE_W-1:0]       acc_base;
   logic [PHASE_W-1:0]       new_phase;
   logic [PHASE_W-1:0]       acc [CHANNELS];

   always_comb begin
      en           = io_out_ready | ~io_out_valid;
      io_in_ready  = en;
      accept       = io_in_valid & en;
      ch_idx       = 32'(io_in_channel);
      in_range     = ch_idx < 32'(CHANNELS);
      ch_sel       = in_range ? io_in_channel : '0;
      sample_ext   = EXT_W'(io_in_value);
      sample_shift = sample_ext >>> DEV_SHIFT;
      inc          = io_cfg_carrier + PHASE_W'(sample_shift);
      // A same-cycle clear zeroes the base before the add.
      acc_base     = io_cfg_phase_clear ? '0 : acc[ch_sel];
      new_phase    = acc_base + inc;
   end

   // Clear is independent of en; the accepted channel's write wins over clear
   // because new_phase already starts from zero in that case.
   always_ff @(posedge clock) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
         if (reset) begin
            acc[c] <= '0;
         end else if (accept && in_range && (ch_sel == CH_W'(c))) begin
            acc[c] <= new_phase;
         end else if (io_cfg_phase_clear) begin
            acc[c] <= '0;
         end
      end
   end

   // ---------------------------------------------------------------- pipeline
   logic                    s1_valid;
   logic [TOP_W-1:0]        s1_phase;
   logic [CH_W-1:0]         s1_ch;
   logic                    s2_valid;
   logic [LUT_ADDR_W-1:0]   s2_addr;
   logic                    s2_neg;
   logic [CH_W-1:0]         s2_ch;
   logic                    s3_valid;
   logic [OUT_W-2:0]        s3_mag;
   logic                    s3_neg;
   logic [CH_W-1:0]         s3_ch;
   logic signed [OUT_W-1:0] mag_s;

   assign mag_s = {1'b0, s3_mag};

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid       <= 1'b0;
         s1_phase       <= '0;
         s1_ch          <= '0;
         s2_valid       <= 1'b0;
         s2_addr        <= '0;
         s2_neg         <= 1'b0;
         s2_ch          <= '0;
         s3_valid       <= 1'b0;
         s3_mag         <= '0;
         s3_neg         <= 1'b0;
         s3_ch          <= '0;
         io_out_valid   <= 1'b0;
         io_out_value   <= '0;
         io_out_channel <= '0;
      end else if (en) begin
         // S1: only the quadrant and ROM address bits of the phase travel on.
         s1_valid       <= accept & in_range;
         s1_phase       <= new_phase[PHASE_W-1 -: TOP_W];
         s1_ch          <= io_in_channel;
         // S2: odd quadrants mirror the address (N-1-a == ~a).
         s2_valid       <= s1_valid;
         s2_addr        <= s1_phase[LUT_ADDR_W-1:0] ^ {LUT_ADDR_W{s1_phase[TOP_W-2]}};
         s2_neg         <= s1_phase[TOP_W-1];
         s2_ch          <= s1_ch;
         // S3: registered ROM read.
         s3_valid       <= s2_valid;
         s3_mag         <= rom[s2_addr];
         s3_neg         <= s2_neg;
         s3_ch          <= s2_ch;
         // S4: sign restore.
         io_out_valid   <= s3_valid;
         io_out_value   <= s3_neg ? -mag_s : mag_s;
         io_out_channel <= s3_ch;
      end
   end

endmodule
